alu_cmd_interface: RTL and testbench

ALU_CMD_INTERFACE -- requirements
Module: alu_cmd_interface

---
 rtl/alu_cmd_pkg.sv | 28 ++
 rtl/inactivity_timer.sv | 35 +++
 rtl/alu_cmd_interface.sv | 145 ++++++++++++++
 tb/tb_alu_cmd_interface.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_pkg.sv
`default_nettype none
// ============================================================================
// alu_cmd_pkg: FSM state encoding and frame-length helpers.         Rev 1.0
// ============================================================================
package alu_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] c_st_rx_a    = 3'd0;
  localparam logic [2:0] c_st_rx_b    = 3'd1;
  localparam logic [2:0] c_st_rx_op   = 3'd2;
  localparam logic [2:0] c_st_exec    = 3'd3;
  localparam logic [2:0] c_st_tx_load = 3'd4;
  localparam logic [2:0] c_st_tx_wait = 3'd5;

  localparam logic [3:0] c_max_valid_op = 4'b1001;

  function automatic int unsigned bytes_per_operand(input int unsigned bus_width);
    return bus_width / 8;
  endfunction

  // Result bytes followed by one status byte.
  function automatic int unsigned tx_byte_count(input int unsigned bus_width);
    return bytes_per_operand(bus_width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inactivity_timer.sv
`default_nettype none
// ============================================================================
// inactivity_timer: counts idle cycles, pulses expire on the last one. Rev 1.0
// ============================================================================
module inactivity_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int unsigned c_cw = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  logic [c_cw-1:0] r_count;

  // A clear in the same cycle as the final count suppresses the expiry.
  assign expire = enable && !clear && (r_count == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || !enable || expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_interface.sv
`default_nettype none
// ============================================================================
// alu_cmd_interface: receives A/B/opcode byte frames for an ALU and returns
// the result plus a status byte through a byte transmitter.         Rev 1.0
// ============================================================================
module alu_cmd_interface
  import alu_cmd_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned OP_BITS        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic [OP_BITS-1:0]   alu_op,
  input  logic [BUS_WIDTH-1:0] alu_result,
  input  logic                 alu_zero,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 busy
);

  localparam int unsigned c_nbytes = bytes_per_operand(BUS_WIDTH);
  localparam int unsigned c_ntx    = tx_byte_count(BUS_WIDTH);
  localparam int unsigned c_cw     = $clog2(c_ntx + 1);
  localparam logic [c_cw-1:0] c_last_opnd = c_cw'(c_nbytes - 1);
  localparam logic [c_cw-1:0] c_last_tx   = c_cw'(c_ntx - 1);
  localparam logic [c_cw-1:0] c_one       = c_cw'(1);

  state_t               r_state;
  logic [c_cw-1:0]      r_cnt;
  logic [BUS_WIDTH-1:0] r_shift;
  logic [BUS_WIDTH-1:0] r_result;
  logic [7:0]           r_status;

  logic                 w_tmr_en;
  logic                 w_expire;
  logic                 w_op_invalid;
  logic [BUS_WIDTH-1:0] w_shift_next;
  logic [BUS_WIDTH-1:0] w_res_shift;
  logic [7:0]           w_tx_byte;

  // Operands arrive LSB first: each byte enters at the top and moves down.
  assign w_shift_next = (BUS_WIDTH'(rx_data) << (BUS_WIDTH - 8)) | (r_shift >> 8);
  assign w_res_shift  = r_result >> {r_cnt, 3'b000};
  assign w_tx_byte    = (r_cnt == c_last_tx) ? r_status : w_res_shift[7:0];
  assign w_op_invalid = int'(alu_op) > int'(c_max_valid_op);

  assign w_tmr_en = ((r_state == c_st_rx_a) && (r_cnt != '0)) ||
                    (r_state == c_st_rx_b) || (r_state == c_st_rx_op);
  assign busy     = !((r_state == c_st_rx_a) && (r_cnt == '0));

  inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (w_tmr_en),
    .clear  (rx_done),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_rx_a;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_result <= '0;
      r_status <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (r_state)
        c_st_rx_a, c_st_rx_b: begin
          if (rx_done) begin
            if (r_cnt == c_last_opnd) begin
              r_cnt <= '0;
              if (r_state == c_st_rx_a) begin
                alu_a   <= w_shift_next;
                r_state <= c_st_rx_b;
              end else begin
                alu_b   <= w_shift_next;
                r_state <= c_st_rx_op;
              end
            end else begin
              r_shift <= w_shift_next;
              r_cnt   <= r_cnt + c_one;
            end
          end else if (w_expire) begin
            r_state <= c_st_rx_a;
            r_cnt   <= '0;
          end
        end
        c_st_rx_op: begin
          if (rx_done) begin
            alu_op  <= rx_data[OP_BITS-1:0];
            r_state <= c_st_exec;
          end else if (w_expire) begin
            r_state <= c_st_rx_a;
            r_cnt   <= '0;
          end
        end
        c_st_exec: begin
          r_result <= alu_result;
          r_status <= {6'b0, w_op_invalid, alu_zero};
          r_state  <= c_st_tx_load;
        end
        c_st_tx_load: begin
          if (!tx_busy) begin
            tx_data  <= w_tx_byte;
            tx_start <= 1'b1;
            r_state  <= c_st_tx_wait;
          end
        end
        c_st_tx_wait: begin
          if (tx_done) begin
            if (r_cnt == c_last_tx) begin
              r_cnt   <= '0;
              r_state <= c_st_rx_a;
            end else begin
              r_cnt   <= r_cnt + c_one;
              r_state <= c_st_tx_load;
            end
          end
        end
        default: begin
          r_state <= c_st_rx_a;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_interface.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_interface: random frames against a behavioural frame model.
// ============================================================================
module tb_alu_cmd_interface;

  localparam int unsigned BW  = 32;
  localparam int unsigned OPB = 4;
  localparam int unsigned TMO = 100;
  localparam int unsigned NB  = BW / 8;
  localparam int unsigned NTX = NB + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     rx_data;
  logic           rx_done;
  logic [BW-1:0]  alu_a;
  logic [BW-1:0]  alu_b;
  logic [OPB-1:0] alu_op;
  logic [BW-1:0]  alu_result;
  logic           alu_zero;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           tx_done;
  logic           busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int viol      = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  alu_cmd_interface #(
    .BUS_WIDTH      (BW),
    .OP_BITS        (OPB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  // Simple ALU: ops 0..9 defined, anything else gives 0 with zero flag low.
  function automatic logic [BW-1:0] alu_f(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                          input logic [OPB-1:0] op);
    case (op)
      4'd0:    return a << b[4:0];
      4'd1:    return a >> b[4:0];
      4'd2:    return $signed(a) >>> b[4:0];
      4'd3:    return a + b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ($signed(a) < $signed(b)) ? BW'(1) : '0;
      4'd8:    return a - b;
      4'd9:    return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);
  assign alu_zero   = (alu_op <= 4'd9) && (alu_result == '0);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Transmitter: busy for a few cycles per byte, sometimes lingering past tx_done.
  initial begin
    int hold;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      tick();
      if (tx_start === 1'b1) begin
        got.push_back(tx_data);
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) tick();
        hold    = int'($urandom_range(0, 2));
        tx_done = 1'b1;
        tx_busy = (hold != 0);
        done_cnt++;
        tick();
        tx_done = 1'b0;
        repeat (hold) tick();
        tx_busy = 1'b0;
      end
    end
  end

  // Protocol monitor: tx_start must only follow a cycle where tx_busy was low.
  initial begin
    logic b;
    forever begin
      @(posedge clk);
      b = tx_busy;
      #1;
      if (tx_start === 1'b1) begin
        start_cnt++;
        if (b) viol++;
      end
    end
  end

  task automatic run_frame(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [7:0] op,
                           input bit use_lit, input logic [8*NTX-1:0] lit,
                           input int g0, input int g1);
    logic [7:0]    exp_b[NTX];
    logic [BW-1:0] r;
    int            base, d0, cyc, gap;
    base = got.size();
    d0   = done_cnt;
    r    = alu_f(a, b, op[OPB-1:0]);
    for (int i = 0; i < int'(NB); i++) exp_b[i] = r[8*i +: 8];
    exp_b[NB] = {6'b0, (op[3:0] > 4'd9), (op[3:0] <= 4'd9) && (r == '0)};
    if (use_lit) for (int i = 0; i < int'(NTX); i++) exp_b[i] = lit[8*i +: 8];

    for (int i = 0; i < int'(NB); i++) begin
      gap = (i == 0 && g0 >= 0) ? g0 : (i == 1 && g1 >= 0) ? g1 : int'($urandom_range(0, 3));
      send_byte(a[8*i +: 8], gap);
    end
    chk("alu_a", 64'(alu_a), 64'(a));
    for (int i = 0; i < int'(NB); i++) send_byte(b[8*i +: 8], int'($urandom_range(0, 3)));
    chk("alu_b", 64'(alu_b), 64'(b));
    send_byte(op, int'($urandom_range(0, 3)));
    chk("alu_op", 64'(alu_op), 64'(op[OPB-1:0]));
    tick();
    chk("tx_start_too_early", 64'(tx_start), 64'(0));

    // Stray rx bytes during execution/transmission must be dropped.
    cyc = 0;
    while ((done_cnt - d0) < int'(NTX) && cyc < 3000) begin
      rx_done = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        rx_data = 8'($urandom);
        rx_done = 1'b1;
      end
      tick();
      cyc++;
    end
    rx_done = 1'b0;
    chk("tx_within_budget", 64'(cyc < 3000), 64'(1));
    chk("tx_byte_count", 64'(got.size() - base), 64'(NTX));
    for (int i = 0; i < int'(NTX); i++)
      chk($sformatf("tx_byte%0d", i),
          (base + i < got.size()) ? 64'(got[base + i]) : 64'hDEAD, 64'(exp_b[i]));
    tick();
    chk("idle_after_frame", 64'(busy), 64'(0));
    chk("alu_a_held", 64'(alu_a), 64'(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] ra, rb;
    logic [7:0]    rop;
    int            s0, base, cyc;
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tx_start", 64'(tx_start), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    rst_n = 1'b1;
    tick();

    run_frame(32'd5, 32'd3, 8'h03, 1'b1, 40'h00_0000_0008, -1, -1);
    run_frame(32'd7, 32'd7, 8'h08, 1'b1, 40'h01_0000_0000, -1, -1);
    run_frame(32'h1234_5678, 32'd4, 8'h00, 1'b1, 40'h00_2345_6780, -1, -1);
    run_frame(BW'($urandom), BW'($urandom), 8'h0F, 1'b1, 40'h02_0000_0000, -1, -1);

    // Partial frame abandoned by inactivity.
    s0 = start_cnt;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    repeat (50) tick();
    chk("busy_mid_idle", 64'(busy), 64'(1));
    repeat (60) tick();
    chk("busy_after_timeout", 64'(busy), 64'(0));
    chk("no_tx_after_timeout", 64'(start_cnt - s0), 64'(0));
    run_frame(BW'($urandom), BW'($urandom), 8'h03, 1'b0, '0, -1, -1);

    // Gap just inside the limit keeps the frame; just outside restarts it.
    run_frame(BW'($urandom), BW'($urandom), 8'h05, 1'b0, '0, -1, int'(TMO) - 3);
    send_byte(8'h5A, 0);
    run_frame(BW'($urandom), BW'($urandom), 8'h06, 1'b0, '0, int'(TMO) + 2, -1);

    for (int n = 0; n < 20; n++) begin
      ra  = BW'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : BW'($urandom);
      rop = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      run_frame(ra, rb, rop, 1'b0, '0, -1, -1);
    end

    // Reset while the third result byte is in flight.
    base = got.size();
    for (int i = 0; i < int'(2 * NB + 1); i++) send_byte(8'(i + 1), 0);
    cyc = 0;
    while ((got.size() - base) < 3 && cyc < 2000) begin
      rx_done = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        rx_data = 8'($urandom);
        rx_done = 1'b1;
      end
      tick();
      cyc++;
    end
    rx_done = 1'b0;
    chk("reached_third_tx_byte", 64'(got.size() - base), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_start", 64'(tx_start), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_alu_a", 64'(alu_a), 64'(0));
    chk("arst_alu_b", 64'(alu_b), 64'(0));
    chk("arst_alu_op", 64'(alu_op), 64'(0));
    chk("arst_tx_data", 64'(tx_data), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (60) tick();
    chk("no_tx_after_reset", 64'(start_cnt - s0), 64'(0));
    chk("idle_after_reset", 64'(busy), 64'(0));
    run_frame(BW'($urandom), BW'($urandom), 8'h04, 1'b0, '0, -1, -1);

    chk("tx_start_while_busy", 64'(viol), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
